// File: rtl/axi_rd_arbiter.sv
// Merges NPORT cache-style read-refill ports onto one AXI4 AR/R channel pair, one outstanding burst per port.
// Define AXI_RD_ARB_PRIO0_EN for fixed priority (lowest index wins); the default build is round-robin.
module axi_rd_arbiter #(
  parameter int NPORT    = 2,
  parameter int ID_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      rd_req,
  input  logic [3*NPORT-1:0]    rd_type,
  input  logic [32*NPORT-1:0]   rd_addr,
  output logic [NPORT-1:0]      rd_rdy,
  output logic [NPORT-1:0]      ret_valid,
  output logic                  ret_last,
  output logic [31:0]           ret_data,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  err
);

  logic [NPORT-1:0] busy;
  logic [NPORT-1:0] elig;
  logic             slot_free;
  logic             gnt_any;
  logic             grant;
  logic             bad_type;
  logic             beat_ok;
  int unsigned      idx;
  int unsigned      gnt_idx;
  logic [31:0]      gnt_addr;
  logic [2:0]       gnt_type;
  logic [7:0]       gnt_len;
  logic [2:0]       gnt_size;

`ifndef AXI_RD_ARB_PRIO0_EN
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  // ptr holds the next index to search from, i.e. last granted + 1
  logic [PW-1:0] ptr;
`endif

  assign elig      = rd_req & ~busy;
  assign slot_free = ~arvalid | arready;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = 0;
    gnt_addr = '0;
    gnt_type = '0;
    idx      = 0;
    rd_rdy   = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
`ifdef AXI_RD_ARB_PRIO0_EN
      idx = k;
`else
      idx = k + 32'(ptr);
      if (idx >= NPORT) idx = idx - NPORT;
`endif
      if (!gnt_any && elig[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx;
        gnt_addr = rd_addr[idx*32 +: 32];
        gnt_type = rd_type[idx*3 +: 3];
      end
    end
    if (gnt_any && slot_free) rd_rdy[gnt_idx] = 1'b1;
  end

  assign grant = |rd_rdy;

  always_comb begin
    bad_type = 1'b0;
    gnt_len  = '0;
    gnt_size = gnt_type;
    case (gnt_type)
      3'd4: begin
        gnt_len  = 8'd3;
        gnt_size = 3'd2;
      end
      3'd0, 3'd1, 3'd2: ;
      default: begin
        gnt_size = 3'd2;
        bad_type = 1'b1;
      end
    endcase
  end

  always_comb begin
    ret_valid = '0;
    for (int unsigned i = 0; i < NPORT; i++)
      ret_valid[i] = rvalid && (rid == ID_WIDTH'(i)) && busy[i];
  end

  // Beats for out-of-range or idle IDs fall out here as !beat_ok
  assign beat_ok  = |ret_valid;
  assign ret_data = rdata;
  assign ret_last = rlast;
  assign rready   = 1'b1;
  assign arburst  = 2'b01;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      busy    <= '0;
      err     <= 1'b0;
`ifndef AXI_RD_ARB_PRIO0_EN
      ptr     <= '0;
`endif
    end else begin
      if (grant) begin
        arvalid <= 1'b1;
        arid    <= ID_WIDTH'(gnt_idx);
        araddr  <= gnt_addr;
        arlen   <= gnt_len;
        arsize  <= gnt_size;
`ifndef AXI_RD_ARB_PRIO0_EN
        ptr     <= (gnt_idx == NPORT - 1) ? '0 : PW'(gnt_idx + 1);
`endif
      end else if (arready) begin
        arvalid <= 1'b0;
      end
      busy <= (busy & ~(ret_valid & {NPORT{rlast}})) | rd_rdy;
      if ((rvalid && (!beat_ok || rresp != 2'b00)) || (grant && bad_type))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_axi_rd_arbiter;
  localparam int NPORT    = 2;
  localparam int ID_WIDTH = 4;

  logic                clock = 1'b0;
  logic                resetn;
  logic [NPORT-1:0]    rd_req;
  logic [3*NPORT-1:0]  rd_type;
  logic [32*NPORT-1:0] rd_addr;
  logic [NPORT-1:0]    rd_rdy, ret_valid;
  logic                ret_last;
  logic [31:0]         ret_data;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid, arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready, err;

  axi_rd_arbiter #(.NPORT(NPORT), .ID_WIDTH(ID_WIDTH)) dut (
    .clock(clock), .resetn(resetn), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .err(err)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit          m_busy[NPORT];
  int          rem[NPORT];
  int          m_next;
  bit          m_err;
  bit          m_arvalid;
  int          m_arid, m_arlen, m_arsize;
  logic [31:0] m_araddr;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NPORT; p++) begin
      m_busy[p] = 0;
      rem[p] = 0;
    end
    m_next = 0; m_err = 0; m_arvalid = 0;
    m_arid = 0; m_arlen = 0; m_arsize = 0; m_araddr = '0;
  endtask

  function automatic int exp_grant();
    if (m_arvalid && !arready) return -1;
    for (int k = 0; k < NPORT; k++) begin
      int p;
`ifdef AXI_RD_ARB_PRIO0_EN
      p = k;
`else
      p = (m_next + k) % NPORT;
`endif
      if (rd_req[p] && !m_busy[p]) return p;
    end
    return -1;
  endfunction

  function automatic int rand_type();
    int tbl[4] = '{0, 1, 2, 4};
    return tbl[$urandom_range(0, 3)];
  endfunction

  task automatic set_port(input int p, input int t, input logic [31:0] a);
    rd_type[p*3 +: 3]  = 3'(t);
    rd_addr[p*32 +: 32] = a;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int g, t;
    logic [NPORT-1:0] e_rdy, e_rv;
    @(negedge clock);
    g = exp_grant();
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_rv = '0;
    for (int p = 0; p < NPORT; p++)
      if (rvalid && rid == ID_WIDTH'(p) && m_busy[p]) e_rv[p] = 1'b1;
    chk("rd_rdy", rd_rdy, e_rdy);
    chk("ret_valid", ret_valid, e_rv);
    chk("ret_last", ret_last, rlast);
    chk("ret_data", ret_data, rdata);
    chk("arvalid", arvalid, m_arvalid);
    chk("arid", arid, m_arid);
    chk("araddr", araddr, m_araddr);
    chk("arlen", arlen, m_arlen);
    chk("arsize", arsize, m_arsize);
    chk("arburst", arburst, 2'b01);
    chk("rready", rready, 1'b1);
    chk("err", err, m_err);
    @(posedge clock);
    if (rvalid) begin
      if (rid < NPORT && m_busy[rid]) begin
        if (rresp != 0) m_err = 1;
        rem[rid]--;
        if (rlast) m_busy[rid] = 0;
      end else m_err = 1;
    end
    if (g >= 0) begin
      t = int'(rd_type[g*3 +: 3]);
      if (t == 4) begin m_arlen = 3; m_arsize = 2; end
      else if (t <= 2) begin m_arlen = 0; m_arsize = t; end
      else begin m_arlen = 0; m_arsize = 2; m_err = 1; end
      m_arvalid = 1; m_arid = g; m_araddr = rd_addr[g*32 +: 32];
      m_busy[g] = 1; rem[g] = m_arlen + 1;
      m_next = (g + 1) % NPORT;
    end else if (arready) m_arvalid = 0;
    #1;
  endtask

  task automatic beat_for(input int p);
    rvalid = 1; rid = ID_WIDTH'(p); rdata = $urandom; rresp = 0;
    rlast = (rem[p] == 1);
  endtask

  task automatic slave_random();
    int p;
    rvalid = 0; rlast = 0; rresp = 0;
    p = $urandom_range(0, NPORT - 1);
    if (m_busy[p] && rem[p] > 0 && $urandom_range(0, 1) == 1) beat_for(p);
  endtask

  task automatic slave_first();
    rvalid = 0; rlast = 0; rresp = 0;
    for (int p = NPORT - 1; p >= 0; p--)
      if (m_busy[p] && rem[p] > 0) beat_for(p);
  endtask

  task automatic drain();
    bit done = 0;
    rd_req = '0; arready = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      done = !m_arvalid;
      for (int p = 0; p < NPORT; p++) if (m_busy[p]) done = 0;
      if (!done) begin
        slave_first();
        cycle();
      end
    end
    rvalid = 0; rlast = 0;
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
  endtask

  task automatic do_reset();
    resetn = 0; rd_req = '0; rvalid = 0; rlast = 0; rid = '0; rresp = '0; rdata = '0; arready = 0;
    #1;
    model_reset();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arid", arid, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_ret_valid", ret_valid, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1;
  endtask

  initial begin
    rd_type = '0; rd_addr = '0;
    do_reset();

    // Single line refill on port 0
    arready = 1;
    set_port(0, 4, 32'h100); rd_req = 2'b01;
    cycle();
    rd_req = '0;
    cycle();
    for (int b = 0; b < 4; b++) begin
      beat_for(0);
      cycle();
    end
    rvalid = 0; rlast = 0;
    cycle();

    // Contention: both ports request every cycle, single-word reads
    rd_req = 2'b11;
    for (int i = 0; i < 16; i++) begin
      set_port(0, 2, $urandom); set_port(1, 2, $urandom);
      slave_first();
      cycle();
    end
    drain();

    // AR backpressure: fields must hold, no further grants
    arready = 0;
    set_port(0, 2, 32'hA000_0004); rd_req = 2'b01;
    cycle();
    set_port(1, 1, 32'hB000_0002); rd_req = 2'b10;
    repeat (5) cycle();
    arready = 1;
    cycle();
    drain();

    // Interleaved R beats on two outstanding line fills
    set_port(0, 4, 32'h200); set_port(1, 4, 32'h300); rd_req = 2'b11;
    cycle(); cycle();
    rd_req = '0;
    for (int b = 0; b < 8; b++) begin
      beat_for((b % 2 == 0) ? 1 : 0);
      cycle();
    end
    rvalid = 0; rlast = 0;
    drain();

    // Same-port reissue: rlast and rd_req coincide
    set_port(0, 0, 32'h41); rd_req = 2'b01;
    cycle();
    rd_req = '0;
    cycle();
    rd_req = 2'b01; beat_for(0);
    cycle();
    rvalid = 0; rlast = 0;
    cycle();
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rd_req = NPORT'($urandom);
      arready = $urandom_range(0, 3) != 0;
      for (int p = 0; p < NPORT; p++) set_port(p, rand_type(), $urandom);
      slave_random();
      cycle();
    end
    drain();

    // Stray beat with an ID beyond NPORT
    rvalid = 1; rid = 4'd3; rlast = 1; rdata = 32'hDEAD_BEEF;
    cycle();
    rvalid = 0; rlast = 0;
    cycle();
    do_reset();

    // Error response on a word read: delivered, err sticky
    arready = 1;
    set_port(1, 2, 32'h1000); rd_req = 2'b10;
    cycle();
    rd_req = '0;
    cycle();
    beat_for(1); rresp = 2'b10;
    cycle();
    rvalid = 0; rlast = 0; rresp = 0;
    repeat (3) cycle();
    do_reset();

    // Unsupported type is issued as a word and flags err
    arready = 1;
    set_port(0, 5, 32'h2000); rd_req = 2'b01;
    cycle();
    rd_req = '0;
    cycle();
    drain();
    cycle();
    do_reset();

    // Reset during beat 2 of a line burst
    arready = 1;
    set_port(0, 4, 32'h3000); rd_req = 2'b01;
    cycle();
    rd_req = '0;
    cycle();
    beat_for(0);
    cycle();
    beat_for(0);
    #1 resetn = 0;
    #1;
    model_reset();
    chk("midrst_arvalid", arvalid, 1'b0);
    chk("midrst_ret_valid", ret_valid, 0);
    chk("midrst_err", err, 1'b0);
    rvalid = 0; rlast = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    set_port(1, 2, 32'h4000); rd_req = 2'b10;
    cycle();
    rd_req = '0;
    rvalid = 1; rid = 4'd0; rlast = 0; rdata = $urandom;
    cycle();
    rvalid = 0;
    cycle();
    drain();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Parametrised read-refill arbiter that merges NPORT cache-style read request ports (rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data) onto one AXI4 read-address/read-data channel pair. It generalises the fixed icache+dcache read path to any number of requesters and allows one outstanding burst per port, with responses routed back by RID. It sits between the caches (or other refill masters) and the AXI interconnect/RAM; the write channel is handled elsewhere.

## Interface
- NPORT, 2: number of requester ports; 1..2^ID_WIDTH
- ID_WIDTH, 4: AXI ID width; ARID = port index
- clock  in  1  system clock, all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- rd_req  in  NPORT  per-port read request
- rd_type  in  3*NPORT  per-port type: 0 byte, 1 half, 2 word, 4 cache line (4 beats)
- rd_addr  in  32*NPORT  per-port address
- rd_rdy  out  NPORT  one-hot grant, combinational
- ret_valid  out  NPORT  per-port return beat valid
- ret_last  out  1  last beat of returned burst (shared)
- ret_data  out  32  return data (shared)
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/32/8/3/2/1  AXI AR
- arready  in  1  AXI AR ready
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI R
- rready  out  1  constant 1
- err  out  1  sticky error flag

## Operation
- busy[i] per port: set on grant of port i, cleared on accepted R beat with rlast=1 and rid=i.
- AR slot free when arvalid=0, or arvalid=1 and arready=1 this cycle.
- Eligible: rd_req[i] & ~busy[i]. If slot free and any eligible, grant exactly one: rd_rdy[i]=1 same cycle; fields captured into AR register on the edge.
- Round-robin: pointer starts at 0; search starts at last-granted+1, wraps at NPORT-1 -> 0; pointer updates only on grant.
- AR encoding: arid=i; araddr=rd_addr[i]; type 4 -> arlen=3, arsize=2; type 0/1/2 -> arlen=0, arsize=type; arburst=2'b01 always. Other type values: treated as word, err set.
- arvalid held with stable fields until arready; never withdrawn.
- R routing: ret_valid[i]=rvalid & (rid==i) & busy[i]; ret_data=rdata, ret_last=rlast, combinational. rready=1; caches must accept every beat.
- rid >= NPORT or rid of a non-busy port: beat dropped, err set. rresp!=0: beat delivered, err set.
- err cleared only by reset.

## Timing
- Reset: arvalid=0, araddr=0, arid=0, arlen=0, arsize=0, arburst=2'b01, busy=0, pointer=0, err=0; rd_rdy/ret_* follow combinational rules (all 0 with no stimulus).
- Request-to-arvalid: 1 cycle after rd_rdy.
- Back-to-back: with arready held 1, one AR per cycle across different ports.
- Same-port reissue: earliest rd_rdy is the cycle after the rlast beat for that port.
- Simultaneous rlast for port i and rd_req[i]: no grant that cycle (busy still set); grant next cycle.
- Reset mid-burst: all state cleared; subsequent stray beats from the old burst set err.

## Configuration
- AXI_RD_ARB_PRIO0_EN defined: fixed priority, lowest eligible index wins (port 0 = icache highest); pointer unused.
- Undefined: round-robin as above.

## Test plan
- Single line refill: port 0 rd_type=4, addr 0x100; RAM returns 4 beats -> arlen=3, arsize=2, arid=0; ret_valid[0] x4, ret_last on beat 4 only.
- Contention: ports 0 and 1 request every cycle, arready=1 -> grants alternate 0,1,0,1 (with PRIO0_EN: port 0 re-granted after each rlast, port 1 only while port 0 busy).
- Interleaved R: ports 0,1 outstanding, slave returns rid 1,0,1,0... -> each beat on the correct ret_valid, both busy clear on respective rlast.
- Backpressure: arready=0 for 5 cycles -> arvalid and fields stable, no further rd_rdy.
- Errors: rresp=2 on a word read -> data delivered, err=1 and stays 1; rid=3 with NPORT=2 -> no ret_valid, err=1.
- Reset during beat 2 of a line burst -> arvalid=0, busy=0 immediately; new request granted first cycle after resetn rises.
